instr_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the instruction decoder and the datapath: fetches a 32-bit word, holds it in an instruction register feeding the decoder, evaluates the condition field against NZCV, and issues register-file, flag, data-memory and PC-update strobes.
- Sits between instruction/data memory handshakes and the combinational decoder. It is the only sequential control element in the core.

---
 rtl/instr_sequencer_pkg.sv | 56 +++++
 rtl/instr_sequencer_if.sv | 30 +++
 rtl/instr_sequencer_cond_eval.sv | 45 ++++
 rtl/instr_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// instr_sequencer_pkg
// Shared definitions for the instruction sequencer:
//   - state_e      : FSM state encoding (also exported on the debug port)
//   - COND_*       : condition-field codes in ir[31:28]
//   - FLAG_*       : bit positions inside the NZCV flag vector
//   - OP_*         : major opcode classes from ir[27:26]
//   - branch_target: pc-relative branch destination helper
// ---------------------------------------------------------------------------
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Branch destination: the offset is a signed word count relative to
    // pc+8; the sum wraps modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_cur,
                                                  input logic [23:0] imm);
        logic signed [31:0] offset;
        offset = {{6{imm[23]}}, imm, 2'b00};
        return pc_cur + 32'd8 + $unsigned(offset);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the memory system (slave).
//   imem_req/imem_addr  : fetch request and address (master -> slave)
//   imem_ack/imem_rdata : fetch completion and fetched word (slave -> master)
//   dmem_req/dmem_we    : data access request and write select (master -> slave)
//   dmem_ack            : data access completion (slave -> master)
// ---------------------------------------------------------------------------
interface instr_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );

endinterface

// File: rtl/instr_sequencer_cond_eval.sv
// ---------------------------------------------------------------------------
// instr_sequencer_cond_eval
// Combinational condition-code evaluation.
//   cond : condition field ir[31:28]
//   flag : NZCV flags, [3]=N [2]=Z [1]=C [0]=V
//   pass : 1 when the instruction should execute
// ---------------------------------------------------------------------------
module instr_sequencer_cond_eval
    import instr_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flag,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flag[FLAG_N];
    assign z = flag[FLAG_Z];
    assign c = flag[FLAG_C];
    assign v = flag[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;   // COND_NV: never executes
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control FSM: fetches an instruction word, holds it in ir for
// the decoder, evaluates the condition field against NZCV and issues
// register-file, flag, data-memory and pc-update strobes.
// Ports:
//   clk, rst_n       : core clock, asynchronous active-low reset
//   bus (master)     : instruction/data memory handshakes
//   ir               : instruction register, feeds the decoder
//   flag             : current NZCV flags (sampled in DECODE only)
//   dec_*            : decoder outputs for the instruction in ir
//   rf_we, flag_we   : one-cycle write strobes
//   pc               : program counter (also the fetch address)
//   fault            : sticky memory-ack timeout
//   state            : current FSM state, for debug
// ---------------------------------------------------------------------------
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instr_sequencer_if.master        bus,
    output logic [31:0]              ir,
    input  logic [3:0]               flag,
    input  logic                     dec_jmp_en,
    input  logic                     dec_flag_en,
    input  logic                     dec_data_w_en,
    input  logic                     dec_data_mem_en,
    input  logic                     dec_data_mem,
    input  logic [23:0]              dec_imm,
    output logic                     rf_we,
    output logic                     flag_we,
    output logic [31:0]              pc,
    output logic                     fault,
    output logic [2:0]               state
);

    // Last wait count before a timeout fires; TIMEOUT non-acked request
    // cycles in a row abort the access.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] ir_q,        ir_d;
    logic        cond_pass_q, cond_pass_d;
    logic        fault_q,     fault_d;
    logic [7:0]  wait_q,      wait_d;
    logic        imem_req_q,  imem_req_d;
    logic        dmem_req_q,  dmem_req_d;
    logic        dmem_we_q,   dmem_we_d;
    logic        rf_we_q,     rf_we_d;
    logic        flag_we_q,   flag_we_d;

    logic        cond_pass;

    instr_sequencer_cond_eval u_cond_eval (
        .cond (ir_q[31:28]),
        .flag (flag),
        .pass (cond_pass)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        cond_pass_d = cond_pass_q;
        fault_d     = fault_q;
        wait_d      = wait_q;
        rf_we_d     = 1'b0;
        flag_we_d   = 1'b0;

        case (state_q)
            FETCH: begin
                // The request flop lags reset release by one cycle; acks
                // before it rises belong to nobody and are ignored.
                if (imem_req_q) begin
                    if (bus.imem_ack) begin
                        ir_d    = bus.imem_rdata;
                        state_d = DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            DECODE: begin
                cond_pass_d = cond_pass;
                state_d     = EXEC;
                // Strobes are registered, so the data-processing writes are
                // prepared here and appear during EXEC.
                if (cond_pass && !dec_jmp_en && !dec_data_mem_en) begin
                    rf_we_d   = dec_data_w_en;
                    flag_we_d = dec_flag_en;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + 32'd4;
                if (cond_pass_q) begin
                    if (dec_jmp_en) begin
                        pc_d = branch_target(pc_q, dec_imm);
                    end else if (dec_data_mem_en) begin
                        pc_d    = pc_q;
                        state_d = MEM;
                    end
                end
            end
            MEM: begin
                if (dmem_req_q) begin
                    if (bus.dmem_ack) begin
                        if (dec_data_mem) begin
                            state_d = WB;
                            rf_we_d = 1'b1;   // visible during WB
                        end else begin
                            pc_d    = pc_q + 32'd4;
                            state_d = FETCH;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            WB: begin
                pc_d    = pc_q + 32'd4;
                state_d = FETCH;
            end
            HALT: begin
            end
            default: begin
                state_d = HALT;
            end
        endcase

        if (state_d != state_q) begin
            wait_d = 8'd0;
        end

        // Requests follow the state being entered so they are registered
        // and drop in the same edge that leaves FETCH/MEM.
        imem_req_d = (state_d == FETCH);
        dmem_req_d = (state_d == MEM);
        dmem_we_d  = (state_d == MEM) && !dec_data_mem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            cond_pass_q <= 1'b0;
            fault_q     <= 1'b0;
            wait_q      <= 8'd0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            flag_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            cond_pass_q <= cond_pass_d;
            fault_q     <= fault_d;
            wait_q      <= wait_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            rf_we_q     <= rf_we_d;
            flag_we_q   <= flag_we_d;
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;
    assign ir            = ir_q;
    assign rf_we         = rf_we_q;
    assign flag_we       = flag_we_q;
    assign pc            = pc_q;
    assign fault         = fault_q;
    assign state         = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer. A small instruction decoder and a
// memory responder surround the DUT; a trace model predicts every cycle of
// each instruction from the instruction-level rules, and a single compare
// process checks the DUT against it on every negative clock edge.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam int         TMO      = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir;
    logic [3:0]  flag_in;
    logic        dec_jmp_en, dec_flag_en, dec_data_w_en;
    logic        dec_data_mem_en, dec_data_mem;
    logic [23:0] dec_imm;
    logic        rf_we, flag_we, fault;
    logic [31:0] pc;
    logic [2:0]  state;

    instr_sequencer_if bus();

    instr_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .ir              (ir),
        .flag            (flag_in),
        .dec_jmp_en      (dec_jmp_en),
        .dec_flag_en     (dec_flag_en),
        .dec_data_w_en   (dec_data_w_en),
        .dec_data_mem_en (dec_data_mem_en),
        .dec_data_mem    (dec_data_mem),
        .dec_imm         (dec_imm),
        .rf_we           (rf_we),
        .flag_we         (flag_we),
        .pc              (pc),
        .fault           (fault),
        .state           (state)
    );

    // Minimal ARM-like decoder: ir[27:26] selects DP/MEM/BR, ir[20] is the
    // S bit for DP and the L bit for memory ops.
    assign dec_jmp_en      = (ir[27:26] == 2'b10);
    assign dec_data_mem_en = (ir[27:26] == 2'b01);
    assign dec_data_w_en   = (ir[27:26] == 2'b00);
    assign dec_flag_en     = (ir[27:26] == 2'b00) && ir[20];
    assign dec_data_mem    = ir[20];
    assign dec_imm         = ir[23:0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Memory responder: ack on the idly-th / ddly-th cycle of a request
    // (0 = never acknowledge).
    logic [31:0] cur_word;
    int          idly, ddly;
    int          icnt, dcnt;

    initial begin
        bus.imem_ack   = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        icnt = 0;
        dcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin
                icnt++;
                bus.imem_ack = (icnt == idly);
            end else begin
                icnt = 0;
                bus.imem_ack = 1'b0;
            end
            if (bus.dmem_req === 1'b1) begin
                dcnt++;
                bus.dmem_ack = (dcnt == ddly);
            end else begin
                dcnt = 0;
                bus.dmem_ack = 1'b0;
            end
            bus.imem_rdata = cur_word;
        end
    end

    // Expected per-cycle observation.
    typedef struct {
        logic [2:0]  st;
        logic        ireq, dreq, dwe, rf, fl, flt;
        logic [31:0] pc;
        logic [31:0] ir;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        cmp_e;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_fault;
    int          cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                cmp_e = exp_q.pop_front();
                checks++;
                if (state !== cmp_e.st || bus.imem_req !== cmp_e.ireq ||
                    bus.dmem_req !== cmp_e.dreq || bus.dmem_we !== cmp_e.dwe ||
                    rf_we !== cmp_e.rf || flag_we !== cmp_e.fl ||
                    pc !== cmp_e.pc || bus.imem_addr !== cmp_e.pc ||
                    ir !== cmp_e.ir || fault !== cmp_e.flt) begin
                    errors++;
                    $display("FAIL trace cyc=%0d got st=%0d ireq=%b dreq=%b dwe=%b rf=%b fl=%b pc=%h addr=%h ir=%h fault=%b expected st=%0d ireq=%b dreq=%b dwe=%b rf=%b fl=%b pc=%h ir=%h fault=%b",
                             cyc, state, bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we, flag_we,
                             pc, bus.imem_addr, ir, fault,
                             cmp_e.st, cmp_e.ireq, cmp_e.dreq, cmp_e.dwe, cmp_e.rf, cmp_e.fl,
                             cmp_e.pc, cmp_e.ir, cmp_e.flt);
                end
            end
        end
    end

    task automatic push(input logic [2:0] st, input logic ireq, input logic dreq,
                        input logic dwe, input logic rf, input logic fl);
        rec_t r;
        r.st = st; r.ireq = ireq; r.dreq = dreq; r.dwe = dwe;
        r.rf = rf; r.fl = fl; r.flt = m_fault; r.pc = m_pc; r.ir = m_ir;
        exp_q.push_back(r);
    endtask

    // Even codes test a base condition, the following odd code its inverse;
    // 1110 always passes and 1111 never does.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? ~base : base;
    endfunction

    task automatic model(input logic [31:0] instr, input logic [3:0] f,
                         input int id, input int dd);
        logic        pass;
        logic [1:0]  op;
        logic [31:0] nxt;
        pass = cond_ref(instr[31:28], f);
        op   = instr[27:26];
        if (id == 0) begin
            repeat (TMO) push(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            m_fault = 1'b1;
            repeat (3) push(S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            repeat (id) push(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            m_ir = instr;
            push(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            push(S_EXEC, 1'b0, 1'b0, 1'b0, pass && op == 2'b00,
                 pass && op == 2'b00 && instr[20]);
            nxt = m_pc + 32'd4;
            if (pass && op == 2'b10)
                nxt = m_pc + 32'd8 + {{6{instr[23]}}, instr[23:0], 2'b00};
            if (pass && op == 2'b01) begin
                repeat (dd) push(S_MEM, 1'b0, 1'b1, ~instr[20], 1'b0, 1'b0);
                if (instr[20]) push(S_WB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            m_pc = nxt;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] instr, input logic [3:0] f,
                       input int id, input int dd, output int ncyc);
        flag_in  = f;
        cur_word = instr;
        idly     = id;
        ddly     = dd;
        model(instr, f, id, dd);
        ncyc = 0;
        while (exp_q.size() != 0 && ncyc < 100) begin
            @(posedge clk);
            #1;
            ncyc++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL run_bound: instr %h still has %0d expected cycles after %0d", instr,
                     exp_q.size(), ncyc);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_outputs", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we, flag_we}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_pc    = 32'd0;
        m_ir    = 32'd0;
        m_fault = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int n;
    int k;

    initial begin
        rst_n    = 1'b0;
        flag_in  = 4'd0;
        cur_word = 32'd0;
        idly     = 1;
        ddly     = 1;
        m_pc     = 32'd0;
        m_ir     = 32'd0;
        m_fault  = 1'b0;

        // AL ADD, single-cycle acks
        do_reset();
        run(32'hE080_0001, 4'b0000, 1, 1, n);
        chk("add_cycles", 32'(n), 32'd3);
        chk("add_pc", pc, 32'd4);
        chk("add_state", 32'(state), 32'd0);

        // BEQ +2 taken / not taken
        do_reset();
        run(32'h0A00_0002, 4'b0100, 1, 1, n);
        chk("beq_taken_pc", pc, 32'd16);
        do_reset();
        run(32'h0A00_0002, 4'b0000, 1, 1, n);
        chk("beq_not_taken_pc", pc, 32'd4);

        // Load with a 3-cycle data ack, then store, backward branch, NOP,
        // and a DP with a slow fetch
        do_reset();
        run(32'hE591_0000, 4'b0000, 1, 3, n);
        chk("load_cycles", 32'(n), 32'd7);
        chk("load_pc", pc, 32'd4);
        run(32'hE581_0000, 4'b0000, 1, 1, n);
        chk("store_cycles", 32'(n), 32'd4);
        chk("store_pc", pc, 32'd8);
        run(32'hEAFF_FFFE, 4'b0000, 1, 1, n);
        chk("branch_back_pc", pc, 32'd8);
        run(32'hEC00_0000, 4'b0000, 1, 1, n);
        chk("nop_pc", pc, 32'd12);
        run(32'hE090_0001, 4'b1111, 3, 1, n);
        chk("slow_fetch_cycles", 32'(n), 32'd5);
        chk("slow_fetch_pc", pc, 32'd16);

        // Fetch never acknowledged
        do_reset();
        run(32'hE080_0001, 4'b0000, 0, 1, n);
        chk("timeout_fault", 32'(fault), 32'd1);
        chk("timeout_state", 32'(state), 32'd5);
        chk("timeout_cycles", 32'(n), 32'(TMO + 3));
        do_reset();

        // Condition sweep: DP with S bit, every cond against every flag value
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                run({4'(c), 28'h090_0001}, 4'(f), 1, 1, n);
            end
        end
        chk("sweep_pc", pc, 32'd1024);

        // Reset in the middle of a store that is never acknowledged
        do_reset();
        cur_word = 32'hE581_0000;
        flag_in  = 4'd0;
        idly     = 1;
        ddly     = 0;
        k = 0;
        while (bus.dmem_req !== 1'b1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mid_dmem_req_before", 32'(bus.dmem_req), 32'd1);
        chk("mid_dmem_we_before", 32'(bus.dmem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dmem", 32'({bus.dmem_req, bus.dmem_we, rf_we, flag_we}), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_pc", pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
